// File: rtl/seg_pipe_adder_pkg.sv
// Shared constants and parameter helpers for the segmented pipelined adder.
package seg_pipe_adder_pkg;

    localparam int unsigned DEF_WIDTH    = 64;
    localparam int unsigned DEF_SEGMENTS = 2;

    function automatic int unsigned slice_width(input int unsigned width,
                                                input int unsigned segments);
        return width / segments;
    endfunction

    function automatic bit params_ok(input int unsigned width,
                                     input int unsigned segments);
        return (segments >= 1) && (segments <= 8) && ((width % segments) == 0);
    endfunction

endpackage

// File: rtl/seg_pipe_adder_if.sv
// Operand/result bundle for seg_pipe_adder.
interface seg_pipe_adder_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_vld;
    logic [WIDTH-1:0] op0;
    logic [WIDTH-1:0] op1;
    logic             out_vld;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output in_vld, op0, op1, input out_vld, sum, cout);
    modport slave  (input in_vld, op0, op1, output out_vld, sum, cout);
endinterface

// File: rtl/seg_add_stage.sv
// One carry-chain slice: adds slice IDX with the incoming carry and forwards
// operands and partial sum to the next slice.
module seg_add_stage
    import seg_pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned SEGMENTS = DEF_SEGMENTS,
    parameter int unsigned IDX      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld_i,
    input  logic             cy_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] s_i,
    output logic             vld_o,
    output logic             cy_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] s_o
);

    localparam int unsigned SW = slice_width(WIDTH, SEGMENTS);
    localparam int unsigned LO = IDX * SW;

    logic [SW:0]      slice_sum;
    logic             vld_d, vld_q;
    logic             cy_d, cy_q;
    logic [WIDTH-1:0] a_d, a_q;
    logic [WIDTH-1:0] b_d, b_q;
    logic [WIDTH-1:0] s_d, s_q;

    // Valid always advances; data only loads with a valid so outputs hold across bubbles.
    always_comb begin
        slice_sum = {1'b0, a_i[LO +: SW]} + {1'b0, b_i[LO +: SW]} + {{SW{1'b0}}, cy_i};
        vld_d     = vld_i;
        cy_d      = cy_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        if (vld_i) begin
            cy_d           = slice_sum[SW];
            a_d            = a_i;
            b_d            = b_i;
            s_d            = s_i;
            s_d[LO +: SW]  = slice_sum[SW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            cy_q  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
        end else begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
        end
    end

    assign vld_o = vld_q;
    assign cy_o  = cy_q;
    assign a_o   = a_q;
    assign b_o   = b_q;
    assign s_o   = s_q;

endmodule

// File: rtl/seg_pipe_adder.sv
// Pipelined unsigned adder: SEGMENTS registered slices, one add per cycle,
// result SEGMENTS edges after the operands are sampled.
module seg_pipe_adder
    import seg_pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned SEGMENTS = DEF_SEGMENTS
) (
    input  logic           clk,
    input  logic           rst_n,
    seg_pipe_adder_if.slave bus
);

    if (!params_ok(WIDTH, SEGMENTS)) begin : g_bad_params
        $error("seg_pipe_adder: SEGMENTS must be 1..8 and divide WIDTH");
    end

    logic             vld_p [SEGMENTS+1];
    logic             cy_p  [SEGMENTS+1];
    logic [WIDTH-1:0] a_p   [SEGMENTS+1];
    logic [WIDTH-1:0] b_p   [SEGMENTS+1];
    logic [WIDTH-1:0] s_p   [SEGMENTS+1];

    assign vld_p[0] = bus.in_vld;
    assign cy_p[0]  = 1'b0;
    assign a_p[0]   = bus.op0;
    assign b_p[0]   = bus.op1;
    assign s_p[0]   = '0;

    for (genvar g = 0; g < SEGMENTS; g++) begin : g_stage
        seg_add_stage #(
            .WIDTH    (WIDTH),
            .SEGMENTS (SEGMENTS),
            .IDX      (g)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .vld_i (vld_p[g]),
            .cy_i  (cy_p[g]),
            .a_i   (a_p[g]),
            .b_i   (b_p[g]),
            .s_i   (s_p[g]),
            .vld_o (vld_p[g+1]),
            .cy_o  (cy_p[g+1]),
            .a_o   (a_p[g+1]),
            .b_o   (b_p[g+1]),
            .s_o   (s_p[g+1])
        );
    end

    // Operand copies leaving the last slice are fully consumed; sink them.
    logic unused_ops;
    assign unused_ops = ^{a_p[SEGMENTS], b_p[SEGMENTS]};

    assign bus.out_vld = vld_p[SEGMENTS];
    assign bus.sum     = s_p[SEGMENTS];
    assign bus.cout    = cy_p[SEGMENTS];

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Scoreboard bench: four adder instances (SEGMENTS 1,2,4,8) fed identical stimulus.
module tb_seg_pipe_adder;

    typedef struct {
        logic [63:0] s;
        logic        c;
        int unsigned t;
    } item_t;

    logic        clk;
    logic        rst_n;
    logic        in_vld;
    logic [63:0] op0;
    logic [63:0] op1;

    int unsigned cyc;
    int          n_assert;
    int          n_fail;
    item_t       issued[$];
    int          rd[4];
    logic [63:0] hold_s[4];
    logic        hold_c[4];

    seg_pipe_adder_if #(.WIDTH(64)) if1 ();
    seg_pipe_adder_if #(.WIDTH(64)) if2 ();
    seg_pipe_adder_if #(.WIDTH(64)) if4 ();
    seg_pipe_adder_if #(.WIDTH(64)) if8 ();

    assign if1.in_vld = in_vld;  assign if1.op0 = op0;  assign if1.op1 = op1;
    assign if2.in_vld = in_vld;  assign if2.op0 = op0;  assign if2.op1 = op1;
    assign if4.in_vld = in_vld;  assign if4.op0 = op0;  assign if4.op1 = op1;
    assign if8.in_vld = in_vld;  assign if8.op0 = op0;  assign if8.op1 = op1;

    seg_pipe_adder #(.WIDTH(64), .SEGMENTS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    seg_pipe_adder #(.WIDTH(64), .SEGMENTS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    seg_pipe_adder #(.WIDTH(64), .SEGMENTS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    seg_pipe_adder #(.WIDTH(64), .SEGMENTS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input int k, input int unsigned S, input logic ov,
                              input logic [63:0] s, input logic co);
        bit    due;
        item_t it;
        due = (rd[k] < issued.size()) && (issued[rd[k]].t + S == cyc);
        chk($sformatf("S%0d out_vld cyc%0d", S, cyc), 65'(ov), 65'(due));
        if (ov === 1'b1 && rd[k] < issued.size()) begin
            it = issued[rd[k]];
            rd[k]++;
            chk($sformatf("S%0d sum cyc%0d", S, cyc), 65'(s), 65'(it.s));
            chk($sformatf("S%0d cout cyc%0d", S, cyc), 65'(co), 65'(it.c));
            hold_s[k] = it.s;
            hold_c[k] = it.c;
        end else begin
            chk($sformatf("S%0d sum hold cyc%0d", S, cyc), 65'(s), 65'(hold_s[k]));
            chk($sformatf("S%0d cout hold cyc%0d", S, cyc), 65'(co), 65'(hold_c[k]));
        end
    endtask

    task automatic check_all();
        check_inst(0, 1, if1.out_vld, if1.sum, if1.cout);
        check_inst(1, 2, if2.out_vld, if2.sum, if2.cout);
        check_inst(2, 4, if4.out_vld, if4.sum, if4.cout);
        check_inst(3, 8, if8.out_vld, if8.sum, if8.cout);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " S1"}, {if1.out_vld, if1.cout, if1.sum[62:0]} | 65'(if1.sum[63]), '0);
        chk({tag, " S2"}, {if2.out_vld, if2.cout, if2.sum[62:0]} | 65'(if2.sum[63]), '0);
        chk({tag, " S4"}, {if4.out_vld, if4.cout, if4.sum[62:0]} | 65'(if4.sum[63]), '0);
        chk({tag, " S8"}, {if8.out_vld, if8.cout, if8.sum[62:0]} | 65'(if8.sum[63]), '0);
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] es, input logic ec);
        @(negedge clk);
        check_all();
        in_vld = v;
        op0    = a;
        op1    = b;
        if (v) issued.push_back('{s: es, c: ec, t: cyc});
    endtask

    task automatic step(input logic v, input logic [63:0] a, input logic [63:0] b);
        logic [64:0] r;
        r = {1'b0, a} + {1'b0, b};
        drive(v, a, b, r[63:0], r[64]);
    endtask

    task automatic discard_in_flight();
        for (int k = 0; k < 4; k++) begin
            rd[k]     = issued.size();
            hold_s[k] = '0;
            hold_c[k] = 1'b0;
        end
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_vld   = 1'b0;
        op0      = '0;
        op1      = '0;
        discard_in_flight();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset held");
        rst_n = 1'b1;

        // Carry crossing the slice boundary, then full-width wrap.
        drive(1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'h0000_0001_0000_0000, 1'b0);
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 1'b1);

        for (int i = 0; i < 5; i++) begin
            ra = 64'($urandom) * 64'($urandom);
            rb = 64'($urandom) * 64'($urandom);
            step(1'b1, ra, rb);
        end

        drive(1'b1, 64'd10, 64'd20, 64'd30, 1'b0);
        step(1'b0, 64'hDEAD_BEEF_0000_0001, 64'h1234_5678_9ABC_DEF0);
        drive(1'b1, 64'd7, 64'd8, 64'd15, 1'b0);
        repeat (9) step(1'b0, '0, '0);

        // Asynchronous reset between clock edges with results in flight.
        step(1'b1, 64'h0123_4567_89AB_CDEF, 64'h0FED_CBA9_8765_4321);
        step(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001);
        step(1'b1, 64'd5, 64'd6);
        @(posedge clk);
        #2;
        in_vld = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_zero("async reset");
        discard_in_flight();
        @(negedge clk);
        check_zero("reset low");
        rst_n = 1'b1;

        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 3))
                0:       begin ra = '1;                      rb = {32'h0, $urandom}; end
                1:       begin ra = 64'($urandom) * 64'($urandom); rb = 64'($urandom) * 64'($urandom); end
                default: begin ra = {$urandom, $urandom};    rb = {$urandom, $urandom}; end
            endcase
            step($urandom_range(0, 4) != 0, ra, rb);
        end
        repeat (10) step(1'b0, '0, '0);

        chk("drain S1", 65'(rd[0]), 65'(issued.size()));
        chk("drain S2", 65'(rd[1]), 65'(issued.size()));
        chk("drain S4", 65'(rd[2]), 65'(issued.size()));
        chk("drain S8", 65'(rd[3]), 65'(issued.size()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_pipe_adder.md
Name: seg_pipe_adder

Overview:
- Pipelined two-operand unsigned adder with a segmented carry chain.
- Each stage adds one WIDTH/SEGMENTS-bit slice and registers the carry into the next stage.
- Full-width sum appears SEGMENTS cycles after the operands are sampled; throughput is one add per cycle.
- Used as the timing-friendly replacement for a single-cycle WIDTH-bit adder in datapaths that tolerate fixed latency.

Parameters:
- WIDTH, 64, operand and sum width in bits.
- SEGMENTS, 2, number of carry-chain slices, equal to pipeline depth. Must divide WIDTH; legal range 1..8.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_vld  input  1  operands valid this cycle.
- op0  input  WIDTH  addend 0, unsigned.
- op1  input  WIDTH  addend 1, unsigned.
- out_vld  output  1  sum valid.
- sum  output  WIDTH  (op0+op1) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Slice width SW = WIDTH/SEGMENTS. Slice k covers bits [k*SW +: SW].
- Stage 1, on the rising edge with in_vld=1:
  - Add slice 0 of op0/op1 with carry-in 0.
  - Register the slice-0 sum, the slice-0 carry, and slices 1..SEGMENTS-1 of both operands.
- Stage s (s=2..SEGMENTS):
  - Add slice s-1 of the delayed operands plus the registered carry from stage s-1.
  - Register the result together with the already-computed lower sum slices.
- Lower sum slices are carried forward through delay registers so the final stage presents the full sum.
- Latency:
  - Operands sampled at edge N produce sum, cout and out_vld=1 after edge N+SEGMENTS-1, registered outputs.
  - With SEGMENTS=2 the result is valid after the next edge.
  - Result remains stable until the next edge that advances the pipeline.
- Throughput and flow:
  - New operands are accepted every cycle; no backpressure.
  - The in_vld bit travels alongside the data.
  - out_vld mirrors in_vld delayed by SEGMENTS cycles.
- in_vld=0: the stage still advances; out_vld=0 in the corresponding output cycle. sum and cout hold their previous values (data registers are enabled only by the stage valid).
- Arithmetic: unsigned; the sum wraps modulo 2^WIDTH; cout is the true carry out.
- Reset:
  - rst_n low asynchronously clears all pipeline data, carry and valid registers to 0. Outputs read sum=0, cout=0, out_vld=0.
  - Reset mid-operation discards all in-flight operations.
  - The first valid result after release comes SEGMENTS cycles after the first sampled in_vld.
- SEGMENTS=1: degenerates to a single registered adder with latency 1.
- No combinational path from inputs to outputs.

Decomposition:
- Package seg_pipe_adder_pkg holds:
  - default WIDTH and SEGMENTS constants;
  - a function returning SW;
  - an elaboration check that WIDTH % SEGMENTS == 0.
- Sub-module seg_add_stage is instantiated SEGMENTS times via generate. Each instance holds:
  - one SW-bit slice adder with carry-in;
  - result/carry registers;
  - delay registers for the upper operand slices and lower sum slices;
  - its valid bit.

Test Plan:
- Reset: hold rst_n=0 and toggle clk -> sum=0, cout=0, out_vld=0. Assert rst_n asynchronously mid-cycle -> outputs clear without waiting for a clk edge.
- Carry across slice boundary:
  - Stimulus: WIDTH=64, SEGMENTS=2, op0=64'h0000_0000_FFFF_FFFF, op1=1, in_vld=1 for one cycle.
  - Response: out_vld=1 exactly 2 cycles later with sum=64'h0000_0001_0000_0000, cout=0.
- Full wrap: op0=64'hFFFF_FFFF_FFFF_FFFF, op1=1 -> sum=0, cout=1.
- Back-to-back stream:
  - Stimulus: random products of two 32-bit randoms on each operand, 5 consecutive cycles with in_vld=1.
  - Response: each sum equals the reference add in issue order, out_vld high for 5 consecutive cycles, no bubbles.
- Bubbles: in_vld pattern 1,0,1 with op0=10,op1=20 then op0=7,op1=8 -> out_vld pattern 1,0,1 with sums 30 and 15; sum holds 30 during the bubble.
- Parameter sweep: SEGMENTS in {1,4,8} with WIDTH=64, 1000 random vectors -> all match, latency equals SEGMENTS.
